// File: rtl/vec_mac_pe_pkg.sv
// Shared definitions for the vector MAC processing element.
package vec_mac_pe_pkg;

    // Default operand/accumulator width and local RAM address width.
    localparam int DATA_W_DEF     = 32;
    localparam int L_RAM_SIZE_DEF = 6;

    // Control FSM: IDLE when the pipeline is empty, RUN while elements are in flight.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/vec_mac_pe_lram.sv
// Local operand RAM: one write port and one registered, read-first read port.
module pe_lram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write and read on the same edge; the read samples the array before the
    // write lands, so a same-address collision returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vec_mac_pe.sv
// Vector MAC processing element: streams ain against local RAM words and
// accumulates signed dot products, emitting one result per 'last' element.
module vec_mac_pe
    import vec_mac_pe_pkg::*;
#(
    parameter int L_RAM_SIZE = L_RAM_SIZE_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  we,
    input  logic [L_RAM_SIZE-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  valid,
    input  logic [DATA_W-1:0]     ain,
    input  logic [L_RAM_SIZE-1:0] raddr,
    input  logic                  last,
    input  logic                  clr,
    output logic [DATA_W-1:0]     dout,
    output logic                  dvalid,
    output logic                  busy
);

    logic [DATA_W-1:0] ram_rdata;

    // S1 operand register
    logic [DATA_W-1:0] s1_a_q,     s1_a_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    // S2 product register
    logic [DATA_W-1:0] s2_prod_q,  s2_prod_d;
    logic              s2_valid_q, s2_valid_d;
    logic              s2_last_q,  s2_last_d;
    // Accumulator and result
    logic [DATA_W-1:0] acc_q,      acc_d;
    logic [DATA_W-1:0] dout_q,     dout_d;
    logic              dvalid_q,   dvalid_d;
    logic [DATA_W-1:0] sum;
    // Control FSM
    state_t            state_q,    state_d;

    // The RAM's registered read port doubles as the S1 register for operand B.
    pe_lram #(
        .DATA_W (DATA_W),
        .ADDR_W (L_RAM_SIZE)
    ) u_lram (
        .clk   (aclk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // Pipeline, accumulator and result next-state; clr flushes in-flight work
    // but still lets an element arriving on the same edge start a fresh sum.
    always_comb begin
        s1_valid_d = valid;
        s1_last_d  = valid & last;
        s1_a_d     = ain;

        s2_valid_d = s1_valid_q & ~clr;
        s2_last_d  = s1_last_q;
        s2_prod_d  = $signed(s1_a_q) * $signed(ram_rdata);

        sum        = acc_q + s2_prod_q;
        acc_d      = acc_q;
        dout_d     = dout_q;
        dvalid_d   = 1'b0;

        if (clr) begin
            acc_d = '0;
        end else if (s2_valid_q) begin
            if (s2_last_q) begin
                dout_d   = sum;
                dvalid_d = 1'b1;
                acc_d    = '0;
            end else begin
                acc_d = sum;
            end
        end
    end

    // FSM next state follows the valid bits that will be present after this
    // edge, so RUN coincides exactly with a non-empty pipeline.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (s1_valid_d)                 state_d = RUN;
            RUN:  if (!s1_valid_d && !s2_valid_d) state_d = IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_a_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
            state_q    <= IDLE;
        end else begin
            s1_a_q     <= s1_a_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s2_prod_q  <= s2_prod_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            acc_q      <= acc_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            state_q    <= state_d;
        end
    end

    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign busy   = (state_q == RUN);

endmodule
